// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arith ops, bit-serial shifts and shift-add multiply.
// Ports: clk, reset (async high), start/alu_cmd/inA/inB in; busy, done, rslt, doBranch out.
module alu_iter #(
    parameter int W     = 8,
    parameter int CMD_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CMD_W-1:0] alu_cmd,
    input  logic [W-1:0]     inA,
    input  logic [W-1:0]     inB,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     rslt,
    output logic             doBranch
);

    localparam int CW = $clog2(W + 1);

    localparam logic [CMD_W-1:0] OP_NOP  = CMD_W'(5'b00000);
    localparam logic [CMD_W-1:0] OP_BEQ  = CMD_W'(5'b00011);
    localparam logic [CMD_W-1:0] OP_MOV  = CMD_W'(5'b00100);
    localparam logic [CMD_W-1:0] OP_SLT  = CMD_W'(5'b00101);
    localparam logic [CMD_W-1:0] OP_ADD  = CMD_W'(5'b01000);
    localparam logic [CMD_W-1:0] OP_SUB  = CMD_W'(5'b01001);
    localparam logic [CMD_W-1:0] OP_AND  = CMD_W'(5'b01010);
    localparam logic [CMD_W-1:0] OP_OR   = CMD_W'(5'b01011);
    localparam logic [CMD_W-1:0] OP_SHL  = CMD_W'(5'b01100);
    localparam logic [CMD_W-1:0] OP_SHR  = CMD_W'(5'b01101);
    localparam logic [CMD_W-1:0] OP_XOR  = CMD_W'(5'b01111);
    localparam logic [CMD_W-1:0] OP_MUL  = CMD_W'(5'b10010);
    localparam logic [CMD_W-1:0] OP_ROTL = CMD_W'(5'b11110);

    localparam logic [W-1:0] W_V = W[W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [CMD_W-1:0] cmd_q;
    logic [W-1:0]     opa, opb, acc;
    logic [CW-1:0]    cnt;

    logic          accept, is_shift, is_mul, last;
    logic [W-1:0]  amt_full;
    logic [CW-1:0] amt;
    logic [W-1:0]  res_nx, opa_nx, acc_nx;
    logic          br_nx;

    // Decode of the incoming request (only meaningful in IDLE).
    always_comb begin
        is_shift = (alu_cmd == OP_SHL) || (alu_cmd == OP_SHR) ||
                   (alu_cmd == OP_ROTL);
        is_mul   = (alu_cmd == OP_MUL);
        amt_full = inB % W_V;
        amt      = amt_full[CW-1:0];
        br_nx    = (alu_cmd == OP_BEQ) && (inA == inB);
        res_nx   = '0;
        case (alu_cmd)
            OP_ADD:  res_nx = inA + inB;
            OP_SUB:  res_nx = inA - inB;
            OP_AND:  res_nx = inA & inB;
            OP_OR:   res_nx = inA | inB;
            OP_MOV:  res_nx = inB;
            OP_SLT:  res_nx = {{(W-1){1'b0}}, inA < inB};
            OP_XOR:  res_nx = {{(W-1){1'b0}}, ^inA};
            // Zero shift amount finishes without iterating.
            OP_SHL, OP_SHR, OP_ROTL: res_nx = inA;
            OP_BEQ, OP_NOP: res_nx = '0;
            default: res_nx = '0;
        endcase
    end

    // One iteration step on the latched operands.
    always_comb begin
        case (cmd_q)
            OP_SHR:  opa_nx = opa >> 1;
            OP_ROTL: opa_nx = {opa[W-2:0], opa[W-1]};
            default: opa_nx = opa << 1;
        endcase
        acc_nx = opb[0] ? acc + opa : acc;
        last   = (cnt == CW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == FIN);
        accept   = (state == IDLE) && start;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((is_shift && amt != '0) || is_mul) begin
                        state_nx = ITER;
                    end else begin
                        state_nx = FIN;
                    end
                end
            end
            ITER: begin
                if (last) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q    <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cnt      <= '0;
            rslt     <= '0;
            doBranch <= 1'b0;
        end else if (accept) begin
            cmd_q <= alu_cmd;
            opa   <= inA;
            opb   <= inB;
            acc   <= '0;
            cnt   <= is_mul ? CW'(W) : amt;
            if (state_nx == FIN) begin
                rslt     <= res_nx;
                doBranch <= br_nx;
            end
        end else if (state == ITER) begin
            opa <= opa_nx;
            opb <= opb >> 1;
            acc <= acc_nx;
            cnt <= cnt - CW'(1);
            if (last) begin
                rslt     <= (cmd_q == OP_MUL) ? acc_nx : opa_nx;
                doBranch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (W=8 and W=16 instances).
// Ports: none; drives clk/reset and each DUT's request inputs.
module tb_alu_iter;

    localparam logic [4:0] ADD  = 5'b01000;
    localparam logic [4:0] SUB  = 5'b01001;
    localparam logic [4:0] ANDO = 5'b01010;
    localparam logic [4:0] ORO  = 5'b01011;
    localparam logic [4:0] MOV  = 5'b00100;
    localparam logic [4:0] SLT  = 5'b00101;
    localparam logic [4:0] BEQ  = 5'b00011;
    localparam logic [4:0] XORR = 5'b01111;
    localparam logic [4:0] SHL  = 5'b01100;
    localparam logic [4:0] SHR  = 5'b01101;
    localparam logic [4:0] ROTL = 5'b11110;
    localparam logic [4:0] MUL  = 5'b10010;
    localparam logic [4:0] NOP  = 5'b00000;
    localparam logic [4:0] UNK  = 5'b11111;

    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [4:0]  alu_cmd = '0;
    logic [7:0]  inA = '0, inB = '0;
    logic        busy, done, doBranch;
    logic [7:0]  rslt;

    logic        start16 = 0;
    logic [4:0]  cmd16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, br16;
    logic [15:0] r16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_iter #(.W(8), .CMD_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_cmd(alu_cmd),
        .inA(inA), .inB(inB), .busy(busy), .done(done),
        .rslt(rslt), .doBranch(doBranch)
    );

    alu_iter #(.W(16), .CMD_W(5)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .alu_cmd(cmd16),
        .inA(a16), .inB(b16), .busy(busy16), .done(done16),
        .rslt(r16), .doBranch(br16)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op on the 8-bit DUT; operands are scrambled after the
    // start cycle, and an extra start is pulsed in cycle inj (if > 0).
    task automatic run(input logic [4:0] c, input logic [7:0] a,
                       input logic [7:0] b, input int inj,
                       output int lat, output logic [7:0] r,
                       output logic br);
        @(negedge clk);
        while (busy) @(negedge clk);
        alu_cmd = c; inA = a; inB = b; start = 1;
        @(posedge clk); #1;
        start = 0; alu_cmd = ADD; inA = ~a; inB = a ^ 8'h5C;
        lat = 1;
        while (!done && lat < 64) begin
            if (lat == inj) begin
                start = 1; alu_cmd = ADD; inA = 8'hFF; inB = 8'h01;
            end
            @(posedge clk); #1;
            start = 0;
            lat++;
        end
        r  = rslt;
        br = doBranch;
    endtask

    task automatic run16(input logic [4:0] c, input logic [15:0] a,
                         input logic [15:0] b, output int lat,
                         output logic [15:0] r);
        @(negedge clk);
        while (busy16) @(negedge clk);
        cmd16 = c; a16 = a; b16 = b; start16 = 1;
        @(posedge clk); #1;
        start16 = 0; a16 = '1; b16 = '1;
        lat = 1;
        while (!done16 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        r = r16;
    endtask

    typedef struct {
        string      tag;
        logic [4:0] c;
        logic [7:0] a, b;
        int         lat;
        logic [7:0] r;
        logic       br;
    } vec_t;

    vec_t vecs[$] = '{
        '{"add_wrap", ADD,  8'hF0, 8'h20, 1, 8'h10, 1'b0},
        '{"rotl3",    ROTL, 8'h81, 8'h03, 4, 8'h0C, 1'b0},
        '{"rotl8",    ROTL, 8'h81, 8'h08, 1, 8'h81, 1'b0},
        '{"shl2",     SHL,  8'h03, 8'h02, 3, 8'h0C, 1'b0},
        '{"shr12",    SHR,  8'hF0, 8'h0C, 5, 8'h0F, 1'b0},
        '{"and",      ANDO, 8'hF0, 8'h3C, 1, 8'h30, 1'b0},
        '{"or",       ORO,  8'hF0, 8'h3C, 1, 8'hFC, 1'b0},
        '{"mov",      MOV,  8'hF0, 8'h3C, 1, 8'h3C, 1'b0},
        '{"slt_t",    SLT,  8'h03, 8'h05, 1, 8'h01, 1'b0},
        '{"slt_f",    SLT,  8'h05, 8'h03, 1, 8'h00, 1'b0},
        '{"xor_red",  XORR, 8'h07, 8'h00, 1, 8'h01, 1'b0},
        '{"nop",      NOP,  8'h12, 8'h34, 1, 8'h00, 1'b0},
        '{"unknown",  UNK,  8'h12, 8'h34, 1, 8'h00, 1'b0},
        '{"beq_ne",   BEQ,  8'h01, 8'h02, 1, 8'h00, 1'b0},
        '{"mul_ff",   MUL,  8'hFF, 8'hFF, 9, 8'h01, 1'b0},
        '{"beq_eq",   BEQ,  8'h5A, 8'h5A, 1, 8'h00, 1'b1},
        '{"sub_wrap", SUB,  8'h03, 8'h05, 1, 8'hFE, 1'b0}
    };

    initial begin
        int         lat;
        logic [7:0] r;
        logic       br;
        logic [15:0] r2;
        bit         seen;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rslt", rslt, 0);
        check("rst_br", doBranch, 0);
        @(negedge clk);
        reset = 0;

        run(MUL, 8'd13, 8'd11, 4, lat, r, br);
        check("mul_lat", lat, 9);
        check("mul_rslt", r, 8'h8F);
        check("mul_br", br, 0);

        foreach (vecs[i]) begin
            run(vecs[i].c, vecs[i].a, vecs[i].b, 0, lat, r, br);
            check({vecs[i].tag, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].tag, "_rslt"}, r, vecs[i].r);
            check({vecs[i].tag, "_br"}, br, vecs[i].br);
        end

        // rslt holds after done.
        @(posedge clk); #1;
        check("hold_rslt", rslt, 8'hFE);

        // Abort an SHR mid-flight with an async reset.
        @(negedge clk);
        alu_cmd = SHR; inA = 8'h80; inB = 8'd7; start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_abort_busy", busy, 1);
        reset = 1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rslt", rslt, 0);
        check("abort_br", doBranch, 0);
        @(negedge clk);
        reset = 0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        check("abort_no_done", seen, 0);

        run(ADD, 8'h01, 8'h02, 0, lat, r, br);
        check("post_add_lat", lat, 1);
        check("post_add_rslt", r, 8'h03);

        run16(MUL, 16'h0100, 16'h0100, lat, r2);
        check("w16_mul_lat", lat, 17);
        check("w16_mul_rslt", r2, 16'h0000);
        run16(SLT, 16'h8000, 16'h0001, lat, r2);
        check("w16_slt_lat", lat, 1);
        check("w16_slt_rslt", r2, 16'h0000);
        run16(SLT, 16'h0001, 16'h8000, lat, r2);
        check("w16_slt_t", r2, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
